// File: rtl/pdm_stereo_tx_if.sv
// Stereo PCM sample handshake between a sample source and pdm_stereo_tx.
// A pair transfers on a clock edge where pcm_valid and pcm_ready are both high.
interface pdm_stereo_tx_if #(
    parameter int W = 16
);
    logic signed [W-1:0] pcm_left;
    logic signed [W-1:0] pcm_right;
    logic                pcm_valid;
    logic                pcm_ready;

    modport master (output pcm_left, output pcm_right, output pcm_valid, input pcm_ready);
    modport slave  (input pcm_left, input pcm_right, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_stereo_tx.sv
// Stereo PCM-to-PDM transmitter: two 2nd-order sigma-delta loops time-multiplexed on one data line.
// Optional LFSR decision dither is enabled by defining PDM_TX_DITHER_EN.
module pdm_stereo_tx #(
    parameter int CLK_DIV = 8,
    parameter int DECIM   = 64,
    parameter int W       = 16
) (
    input  logic           clk,
    input  logic           reset,
    pdm_stereo_tx_if.slave pcm,
    output logic           clk_out_pdm,
    output logic           dout,
    output logic           underrun
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int IW = W + 4;
    // Working width holds integrator + input + feedback without overflow before clamping.
    localparam int SW = W + 6;

    localparam logic signed [SW-1:0] FB_POS = SW'(2 ** (W - 1));
    localparam logic signed [SW-1:0] FB_NEG = -FB_POS;
    localparam logic signed [SW-1:0] IMAX   = SW'((2 ** (IW - 1)) - 1);
    localparam logic signed [SW-1:0] IMIN   = -SW'(2 ** (IW - 1));

    typedef logic signed [IW-1:0] integ_t;
    typedef logic signed [W-1:0]  samp_t;

    function automatic integ_t sat(input logic signed [SW-1:0] v);
        integ_t r;
        if (v > IMAX)
            r = IMAX[IW-1:0];
        else if (v < IMIN)
            r = IMIN[IW-1:0];
        else
            r = v[IW-1:0];
        return r;
    endfunction

    logic [PW-1:0] ph;
    logic [CW-1:0] pc;
    logic          hold_full;
    samp_t         hold [2];
    samp_t         cur  [2];
    integ_t        i1   [2];
    integ_t        i2   [2];
    logic          prev [2];

    logic                   rise_edge;
    logic                   fall_edge;
    logic                   boundary;
    logic                   accept;
    logic signed [SW-1:0]   fb    [2];
    integ_t                 i1_nx [2];
    integ_t                 i2_nx [2];
    logic                   bit_nx [2];

    assign rise_edge     = (ph == PW'(CLK_DIV / 2 - 1));
    assign fall_edge     = (ph == PW'(CLK_DIV - 1));
    assign boundary      = fall_edge && (pc == CW'(DECIM - 1));
    assign accept        = pcm.pcm_valid && !hold_full;
    assign pcm.pcm_ready = !hold_full;

`ifdef PDM_TX_DITHER_EN
    logic [15:0]          lfsr;
    logic signed [1:0]    dith;
    logic signed [SW-1:0] dsum [2];

    assign dith = lfsr[1:0];

    always_ff @(posedge clk) begin
        if (!reset)
            lfsr <= 16'hACE1;
        else if (rise_edge || fall_edge)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
`endif

    // Index 0 is left (updates on PDM clock rise), index 1 is right (updates on fall).
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            fb[c]     = prev[c] ? FB_POS : FB_NEG;
            i1_nx[c]  = sat(SW'(i1[c]) + SW'(cur[c]) - fb[c]);
            i2_nx[c]  = sat(SW'(i2[c]) + SW'(i1_nx[c]) - fb[c]);
`ifdef PDM_TX_DITHER_EN
            dsum[c]   = SW'(i2_nx[c]) + SW'(dith);
            bit_nx[c] = !dsum[c][SW-1];
`else
            bit_nx[c] = !i2_nx[c][IW-1];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ph          <= '0;
            pc          <= '0;
            clk_out_pdm <= 1'b0;
            dout        <= 1'b0;
            underrun    <= 1'b0;
            hold_full   <= 1'b0;
            hold        <= '{default: '0};
            cur         <= '{default: '0};
            i1          <= '{default: '0};
            i2          <= '{default: '0};
            prev        <= '{default: 1'b0};
        end else begin
            ph <= fall_edge ? '0 : ph + PW'(1);

            if (rise_edge) begin
                clk_out_pdm <= 1'b1;
                i1[0]       <= i1_nx[0];
                i2[0]       <= i2_nx[0];
                prev[0]     <= bit_nx[0];
                dout        <= bit_nx[0];
            end

            if (fall_edge) begin
                clk_out_pdm <= 1'b0;
                pc          <= boundary ? '0 : pc + CW'(1);
                i1[1]       <= i1_nx[1];
                i2[1]       <= i2_nx[1];
                prev[1]     <= bit_nx[1];
                dout        <= bit_nx[1];
            end

            // The right bit on a boundary edge still uses the outgoing pair.
            if (boundary) begin
                if (hold_full)
                    cur <= hold;
                else
                    underrun <= 1'b1;
            end

            if (accept) begin
                hold[0] <= pcm.pcm_left;
                hold[1] <= pcm.pcm_right;
            end

            hold_full <= accept || (hold_full && !boundary);
        end
    end
endmodule
